// File: rtl/instruction_flash_loader_pkg.sv
// Shared types and constants for the instruction flash loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package instruction_flash_loader_pkg;

  // Loader session states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } loader_state_t;

  // One instruction word is written as four little-endian byte lanes
  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = 8;
  localparam int WORD_W         = BYTES_PER_WORD * LANE_W;

endpackage

// File: rtl/instruction_flash_loader.sv
// Serialises accepted 32-bit instruction words into four little-endian byte writes to the instruction memory.
// Latency: first flashEn one cycle after word acceptance; 5 cycles per word (1 accept + 4 byte writes).
// Backpressure: wordReady is high only while waiting for a word; the source holds wordValid until accepted.
module instruction_flash_loader
  import instruction_flash_loader_pkg::*;
#(
  parameter int                MEM_BYTES  = 128,
  parameter int                ADDR_W     = 64,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                wordValid,
  input  logic [WORD_W-1:0]   wordData,
  input  logic                wordLast,
  output logic                wordReady,
  output logic                flashEn,
  output logic [ADDR_W-1:0]   flashAddr,
  output logic [LANE_W-1:0]   flashInstruction,
  output logic                busy,
  output logic                done,
  output logic                overflowErr,
  output logic [ADDR_W-3:0]   wordCount
);

  // Capacity compared one bit wider than the address so base+4 can never wrap
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_BYTES);

  loader_state_t        state;
  logic [ADDR_W-1:0]    base;
  logic [1:0]           byte_idx;
  logic [WORD_W-1:0]    word_q;
  logic                 last_q;

  logic [1:0]           next_idx;
  logic [LANE_W-1:0]    next_lane;
  logic [ADDR_W:0]      word_end;
  logic                 word_fits;

  // Next byte lane of the latched word, selected by the upcoming byte index
  always_comb begin
    next_idx = byte_idx + 2'd1;
    next_lane = '0;
    case (next_idx)
      2'd0: next_lane = word_q[7:0];
      2'd1: next_lane = word_q[15:8];
      2'd2: next_lane = word_q[23:16];
      2'd3: next_lane = word_q[31:24];
      default: next_lane = '0;
    endcase
  end

  // Whole-word range check against memory capacity, done before any byte is written
  always_comb begin
    word_end  = {1'b0, base} + (ADDR_W + 1)'(BYTES_PER_WORD);
    word_fits = (word_end <= MEM_LIMIT);
  end

  // Session FSM with address/word counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      base             <= '0;
      byte_idx         <= '0;
      word_q           <= '0;
      last_q           <= 1'b0;
      flashEn          <= 1'b0;
      flashAddr        <= '0;
      flashInstruction <= '0;
      wordReady        <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      overflowErr      <= 1'b0;
      wordCount        <= '0;
    end else begin
      unique case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state       <= WAIT;
            base        <= START_ADDR;
            wordCount   <= '0;
            done        <= 1'b0;
            overflowErr <= 1'b0;
            busy        <= 1'b1;
            wordReady   <= 1'b1;
          end
        end

        WAIT: begin
          if (wordValid && wordReady) begin
            word_q    <= wordData;
            last_q    <= wordLast;
            wordReady <= 1'b0;
            if (!word_fits) begin
              // Overflowing word is consumed but never written, even if flagged last
              state       <= ERROR;
              overflowErr <= 1'b1;
              busy        <= 1'b0;
            end else begin
              state            <= WRITE;
              byte_idx         <= 2'd0;
              flashEn          <= 1'b1;
              flashAddr        <= base;
              flashInstruction <= wordData[LANE_W-1:0];
            end
          end
        end

        WRITE: begin
          if (byte_idx == 2'd3) begin
            flashEn   <= 1'b0;
            wordCount <= wordCount + (ADDR_W - 2)'(1);
            base      <= base + ADDR_W'(BYTES_PER_WORD);
            if (last_q) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= WAIT;
              wordReady <= 1'b1;
            end
          end else begin
            byte_idx         <= next_idx;
            flashAddr        <= base + ADDR_W'(next_idx);
            flashInstruction <= next_lane;
          end
        end

        default: begin
          state     <= IDLE;
          flashEn   <= 1'b0;
          wordReady <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
